// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory waits with timeout, and halt draining.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic [3:0]       ex_wb_dst,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_clear,
    output logic             id_ex_clear,
    output logic             ex_mem_clear,
    output logic             mem_wb_clear,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       dbg_state
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt, wait_nxt;
    logic [DW-1:0]   drain_cnt, drain_nxt;
    logic            halt_set, err_set;
    logic            lu, mw;

    assign lu = ex_mem_to_reg && (ex_wb_dst != 4'd0) &&
                ((id_uses_rs && (id_rs == ex_wb_dst)) || (id_uses_rt && (id_rt == ex_wb_dst)));
    assign mw = mem_req && !mem_ready;
    assign dbg_state = state;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_clear = 1'b0;
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        drain_nxt    = drain_cnt;
        halt_set     = 1'b0;
        err_set      = 1'b0;
        if (rst) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (mw) begin
                        // Freeze everything up to EX/MEM; a branch or halt in EX waits with it.
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                        mem_wb_clear = 1'b1;
                        if (state == RUN) begin
                            wait_nxt  = WW'(1);
                            state_nxt = MEM_WAIT;
                        end else if (wait_cnt == WAIT_LAST) begin
                            // wait_cnt counts earlier not-ready cycles; this one is the last allowed.
                            err_set   = 1'b1;
                            halt_set  = 1'b1;
                            state_nxt = HALTED;
                        end else begin
                            wait_nxt = wait_cnt + WW'(1);
                        end
                    end else begin
                        wait_nxt  = '0;
                        state_nxt = RUN;
                        if (ex_branch_taken) begin
                            if_id_clear = 1'b1;
                            id_ex_clear = 1'b1;
                        end else if (ex_halt) begin
                            pc_stall    = 1'b1;
                            if_id_clear = 1'b1;
                            id_ex_clear = 1'b1;
                            drain_nxt   = '0;
                            state_nxt   = DRAIN;
                        end else if (lu) begin
                            pc_stall    = 1'b1;
                            if_id_stall = 1'b1;
                            id_ex_clear = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_clear = 1'b1;
                    id_ex_clear = 1'b1;
                    if (mw) begin
                        ex_mem_stall = 1'b1;
                        mem_wb_clear = 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            err_set   = 1'b1;
                            halt_set  = 1'b1;
                            state_nxt = HALTED;
                        end else begin
                            wait_nxt = wait_cnt + WW'(1);
                        end
                    end else begin
                        wait_nxt = '0;
                        if (drain_cnt == DRAIN_LAST) begin
                            halt_set  = 1'b1;
                            state_nxt = HALTED;
                        end else begin
                            drain_nxt = drain_cnt + DW'(1);
                        end
                    end
                end
                HALTED: begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_clear = 1'b1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
            if (halt_set) halted <= 1'b1;
            if (err_set) mem_err <= 1'b1;
            if (pc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a rule-level model checked every cycle plus
// hand-computed literal expectations along the scenario sequence.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT  = 15;
    localparam int DRAIN_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic clk, rst;
    logic [3:0] id_rs, id_rt, ex_wb_dst;
    logic id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_branch_taken, ex_halt, mem_req, mem_ready;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear;
    logic halted, mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0] dbg_state;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_wb_dst(ex_wb_dst),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear),
        .ex_mem_clear(ex_mem_clear), .mem_wb_clear(mem_wb_clear),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: outputs derived directly from the hazard rules
    bit m_stop, m_err, m_drain;
    int m_nr, m_drained, m_stalls;
    logic [17:0] exp_q[$];

    // {pc, if_id, id_ex, ex_mem stalls, if_id, id_ex, ex_mem, mem_wb clears}
    function automatic logic [7:0] exp_ctrl();
        logic lu_h, mw_h;
        mw_h = mem_req && !mem_ready;
        lu_h = ex_mem_to_reg && (ex_wb_dst != 0) &&
               ((id_uses_rs && id_rs == ex_wb_dst) || (id_uses_rt && id_rt == ex_wb_dst));
        if (rst) return 8'b0000_1111;
        if (m_stop) return 8'b1111_0001;
        if (m_drain) return mw_h ? 8'b1001_1101 : 8'b1000_1100;
        if (mw_h) return 8'b1111_0001;
        if (ex_branch_taken) return 8'b0000_1100;
        if (ex_halt) return 8'b1000_1100;
        if (lu_h) return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    always @(posedge clk) begin
        logic [7:0] e;
        e = exp_ctrl();
        if (rst) begin
            m_stop = 0; m_err = 0; m_drain = 0; m_nr = 0; m_drained = 0; m_stalls = 0;
        end else begin
            if (e[7] && m_stalls < 65535) m_stalls++;
            if (!m_stop) begin
                if (mem_req && !mem_ready) begin
                    m_nr++;
                    if (m_nr >= MEM_TIMEOUT) begin m_stop = 1; m_err = 1; end
                end else begin
                    m_nr = 0;
                    if (m_drain) begin
                        m_drained++;
                        if (m_drained == DRAIN_CYCLES) m_stop = 1;
                    end else if (!ex_branch_taken && ex_halt) begin
                        m_drain = 1;
                        m_drained = 0;
                    end
                end
            end
        end
        exp_q.push_back({m_stop, m_err, m_stalls[15:0]});
    end

    // Scoreboard compare, mid-cycle
    always @(negedge clk) begin
        logic [17:0] r;
        check("ctrl", int'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                            if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear}), int'(exp_ctrl()));
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 0, 1);
        end else begin
            r = exp_q.pop_front();
            check("halted", int'(halted), int'(r[17]));
            check("mem_err", int'(mem_err), int'(r[16]));
            check("stall_cnt", int'(stall_cnt), int'(r[15:0]));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_to_reg = 0; ex_wb_dst = 0; ex_branch_taken = 0; ex_halt = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic load_use(input logic [3:0] rs, input logic [3:0] rt, input logic urs,
                            input logic urt, input logic [3:0] dst);
        idle();
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_mem_to_reg = 1; ex_wb_dst = dst;
    endtask

    task automatic mem_wait(input logic ready, input logic br);
        idle();
        mem_req = 1; mem_ready = ready; ex_branch_taken = br;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    int flushes;

    initial begin
        rst = 1;
        idle();
        tick();
        #1;
        check("rst_mem_wb_clear", int'(mem_wb_clear), 1);
        check("rst_pc_stall", int'(pc_stall), 0);
        tick();
        rst = 0;
        #1;
        check("reset_stall_cnt", int'(stall_cnt), 0);
        check("reset_halted", int'(halted), 0);
        check("reset_mem_err", int'(mem_err), 0);

        // Load-use: one bubble
        load_use(4'd3, 4'd0, 1, 0, 4'd3);
        #1;
        check("lu_rs", int'({pc_stall, if_id_stall, id_ex_clear}), 7);
        tick();
        idle();
        #1;
        check("lu_one_bubble", int'(pc_stall), 0);
        check("lu_stall_cnt", int'(stall_cnt), 1);
        load_use(4'd1, 4'd5, 0, 1, 4'd5);
        #1;
        check("lu_rt", int'(if_id_stall), 1);
        tick();
        load_use(4'd1, 4'd5, 0, 0, 4'd5);
        #1;
        check("lu_rt_unused", int'(pc_stall), 0);
        tick();
        load_use(4'd0, 4'd0, 1, 1, 4'd0);
        #1;
        check("lu_r0", int'(pc_stall), 0);
        tick();

        // Branch flush, branch beats load-use
        idle();
        ex_branch_taken = 1;
        #1;
        check("br_flush", int'({if_id_clear, id_ex_clear, pc_stall}), 6);
        tick();
        load_use(4'd7, 4'd0, 1, 0, 4'd7);
        ex_branch_taken = 1;
        #1;
        check("br_over_lu", int'({pc_stall, if_id_stall, id_ex_clear}), 1);
        tick();
        check("br_stall_cnt", int'(stall_cnt), 2);

        // Memory wait, 3 not-ready cycles
        for (int i = 0; i < 3; i++) begin
            mem_wait(0, 0);
            #1;
            check("mw_stalls", int'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_clear}), 31);
            tick();
        end
        mem_wait(1, 0);
        #1;
        check("mw_release", int'({pc_stall, ex_mem_stall, mem_wb_clear}), 0);
        tick();
        check("mw_stall_cnt", int'(stall_cnt), 5);

        // Branch frozen in EX during a 2-cycle wait
        flushes = 0;
        for (int i = 0; i < 3; i++) begin
            mem_wait(i == 2, 1);
            #1;
            if (if_id_clear) flushes++;
            tick();
        end
        idle();
        check("br_wait_flush_once", flushes, 1);
        check("br_wait_stall_cnt", int'(stall_cnt), 7);

        // Halt drain without memory traffic
        idle();
        ex_halt = 1;
        #1;
        check("halt_cycle", int'({pc_stall, if_id_clear, id_ex_clear}), 7);
        tick();
        idle();
        check("drain1_halted", int'(halted), 0);
        tick();
        check("drain2_halted", int'(halted), 0);
        tick();
        check("halt_done", int'(halted), 1);
        ex_branch_taken = 1;
        load_use(4'd2, 4'd0, 1, 0, 4'd2);
        #1;
        check("halted_outputs", int'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                                      if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear}), 8'hF1);
        tick();
        do_reset();
        check("rst_after_halt", int'(halted), 0);

        // Halt drain with one memory wait cycle injected
        ex_halt = 1;
        tick();
        mem_wait(0, 0);
        #1;
        check("drain_mw", int'({pc_stall, ex_mem_stall, id_ex_clear, mem_wb_clear, id_ex_stall}), 30);
        tick();
        idle();
        tick();
        check("drain_mw_h1", int'(halted), 0);
        tick();
        check("drain_mw_h2", int'(halted), 1);
        do_reset();

        // Reset in the middle of a wait returns to RUN
        mem_wait(0, 0);
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle();
        #1;
        check("rst_mid_wait", int'({pc_stall, ex_mem_stall, mem_wb_clear}), 0);
        check("rst_mid_wait_cnt", int'(stall_cnt), 0);

        // Timeout: 15 not-ready cycles
        mem_wait(0, 0);
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) begin
            tick();
            check("timeout_early", int'({halted, mem_err}), 0);
        end
        tick();
        check("timeout_hit", int'({halted, mem_err}), 3);
        do_reset();
        check("timeout_rst", int'({halted, mem_err}), 0);
        load_use(4'd4, 4'd0, 1, 0, 4'd4);
        #1;
        check("run_after_rst", int'({pc_stall, if_id_stall, id_ex_clear}), 7);
        tick();

        // Stall counter saturation while halted
        do_reset();
        mem_wait(0, 0);
        for (int i = 0; i < 65540; i++) tick();
        check("stall_cnt_sat", int'(stall_cnt), 16'hFFFF);
        tick();
        check("stall_cnt_sat_hold", int'(stall_cnt), 16'hFFFF);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
